azadi_pad_in_filter: RTL and testbench

//  Input-direction companion to the SoC pin mux: conditions the chip-side pad inputs before

---
 rtl/azadi_pad_in_filter.sv | 88 ++++++++
 tb/tb_azadi_pad_in_filter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/azadi_pad_in_filter.sv
// Pad input conditioner: per-pin synchronizer, optional prescaled debounce filter and
// registered rise/fall pulses, feeding the input side of the pin mux.
module azadi_pad_in_filter #(
   parameter int unsigned IO_PORTS    = 24,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned PRESC_W     = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [IO_PORTS-1:0] io_in_i,
   input  logic [IO_PORTS-1:0] filt_en_i,
   input  logic [CNT_W-1:0]    debounce_thr_i,
   input  logic [PRESC_W-1:0]  prescale_i,
   output logic [IO_PORTS-1:0] pin_o,
   output logic [IO_PORTS-1:0] rise_o,
   output logic [IO_PORTS-1:0] fall_o,
   output logic                any_edge_o
);

   logic [SYNC_STAGES-1:0][IO_PORTS-1:0] r_sync;
   logic [PRESC_W-1:0]                   r_presc;
   logic [IO_PORTS-1:0][CNT_W-1:0]       r_cnt;
   logic [IO_PORTS-1:0][CNT_W-1:0]       w_cnt_d;
   logic [IO_PORTS-1:0]                  r_pin;
   logic [IO_PORTS-1:0]                  w_pin_d;
   logic [IO_PORTS-1:0]                  r_rise;
   logic [IO_PORTS-1:0]                  r_fall;
   logic                                 r_any;
   logic [IO_PORTS-1:0]                  w_s;
   logic                                 w_tick;
   logic [CNT_W:0]                       w_thr_eff;

   // >= compare so a prescale lowered below the running count ticks at once.
   assign w_tick    = (r_presc >= prescale_i);
   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_thr_eff = (debounce_thr_i == '0) ? (CNT_W+1)'(1) : {1'b0, debounce_thr_i};

   always_comb begin
      logic [CNT_W:0] inc;
      w_pin_d = r_pin;
      w_cnt_d = r_cnt;
      inc     = '0;
      for (int k = 0; k < IO_PORTS; k++) begin
         inc = {1'b0, r_cnt[k]} + (CNT_W+1)'(1);
         if (!filt_en_i[k]) begin
            w_pin_d[k] = w_s[k];
            w_cnt_d[k] = '0;
         end else if (w_s[k] == r_pin[k]) begin
            w_cnt_d[k] = '0;
         end else if (w_tick) begin
            if (inc >= w_thr_eff) begin
               w_pin_d[k] = w_s[k];
               w_cnt_d[k] = '0;
            end else begin
               w_cnt_d[k] = inc[CNT_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync  <= '0;
         r_presc <= '0;
         r_cnt   <= '0;
         r_pin   <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         r_any   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], io_in_i};
         r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
         r_cnt   <= w_cnt_d;
         r_pin   <= w_pin_d;
         // Pulses registered alongside the level so they line up with the new pin_o value.
         r_rise  <= w_pin_d & ~r_pin;
         r_fall  <= ~w_pin_d & r_pin;
         r_any   <= |(w_pin_d ^ r_pin);
      end
   end

   assign pin_o      = r_pin;
   assign rise_o     = r_rise;
   assign fall_o     = r_fall;
   assign any_edge_o = r_any;

endmodule

// File: tb/tb_azadi_pad_in_filter.sv
// Directed vector table plus prescaled-debounce sequence and a randomized model comparison
// for azadi_pad_in_filter.
module tb_azadi_pad_in_filter;

   localparam int unsigned IO_PORTS    = 24;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned PRESC_W     = 16;
   localparam logic [23:0] ALL         = 24'hFF_FFFF;

   typedef struct {
      logic        rst;
      logic [23:0] io;
      logic [23:0] fen;
      logic [7:0]  thr;
      logic [15:0] psc;
      logic [23:0] pin;
      logic [23:0] rise;
      logic [23:0] fall;
      logic        any;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] io;
   logic [23:0] fen;
   logic [7:0]  thr;
   logic [15:0] psc;
   logic [23:0] pin_o;
   logic [23:0] rise_o;
   logic [23:0] fall_o;
   logic        any_edge_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [23:0] m_s1, m_s2, m_pin, m_rise, m_fall;
   int          m_cnt [24];
   int          m_presc;

   vec_t vecs[$];

   azadi_pad_in_filter #(
      .IO_PORTS   (IO_PORTS),
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .PRESC_W    (PRESC_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .io_in_i       (io),
      .filt_en_i     (fen),
      .debounce_thr_i(thr),
      .prescale_i    (psc),
      .pin_o         (pin_o),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .any_edge_o    (any_edge_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [23:0] i, input logic [23:0] f,
                               input logic [7:0] t, input logic [15:0] p,
                               input logic [23:0] ep, input logic [23:0] er,
                               input logic [23:0] ef, input logic ea);
      vec_t v;
      v.rst = r; v.io = i; v.fen = f; v.thr = t; v.psc = p;
      v.pin = ep; v.rise = er; v.fall = ef; v.any = ea;
      return v;
   endfunction

   // Advances the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      logic        tk;
      logic [23:0] np;
      int          th;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_pin = '0; m_rise = '0; m_fall = '0; m_presc = 0;
         for (int k = 0; k < 24; k++) m_cnt[k] = 0;
      end else begin
         tk = (m_presc >= int'(psc));
         th = (thr == 0) ? 1 : int'(thr);
         np = m_pin;
         for (int k = 0; k < 24; k++) begin
            if (!fen[k]) begin
               np[k] = m_s2[k];
               m_cnt[k] = 0;
            end else if (m_s2[k] == m_pin[k]) begin
               m_cnt[k] = 0;
            end else if (tk) begin
               if (m_cnt[k] + 1 >= th) begin
                  np[k] = m_s2[k];
                  m_cnt[k] = 0;
               end else begin
                  m_cnt[k] = m_cnt[k] + 1;
               end
            end
         end
         m_rise  = np & ~m_pin;
         m_fall  = ~np & m_pin;
         m_pin   = np;
         m_s2    = m_s1;
         m_s1    = io;
         m_presc = tk ? 0 : m_presc + 1;
      end
   endtask

   initial begin
      int n;
      logic seen;
      rst = 1'b1; io = ALL; fen = '0; thr = 8'd1; psc = '0;

      // Reset with all pads high, then first propagation (filter off)
      vecs.push_back(mk(1, ALL, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, ALL, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ALL, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ALL, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ALL, 0, 1, 0, ALL, ALL, 0, 1));
      vecs.push_back(mk(0, ALL, 0, 1, 0, ALL, 0, 0, 0));
      // All low, then 1-cycle pulse on pin 3
      vecs.push_back(mk(0, 0, 0, 1, 0, ALL, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, ALL, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, ALL, 1));
      vecs.push_back(mk(0, 24'h8, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 24'h8, 24'h8, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 24'h8, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
      // Pin 5 filtered, thr=4: bounce 1,0,1 then steady 1
      vecs.push_back(mk(0, 24'h20, 24'h20, 4, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 24'h20, 4, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 24'h20, 24'h20, 4, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 24'h20, 24'h20, 4, 0, 24'h20, 24'h20, 0, 1));
      vecs.push_back(mk(0, 24'h20, 24'h20, 4, 0, 24'h20, 0, 0, 0));
      // thr=0 behaves like thr=1
      vecs.push_back(mk(0, 0, 24'h20, 0, 0, 24'h20, 0, 0, 0));
      vecs.push_back(mk(0, 0, 24'h20, 0, 0, 24'h20, 0, 0, 0));
      vecs.push_back(mk(0, 0, 24'h20, 0, 0, 0, 0, 24'h20, 1));
      vecs.push_back(mk(0, 0, 24'h20, 0, 0, 0, 0, 0, 0));
      // Filter disabled mid-count: pin follows immediately
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 24'h20, 24'h20, 8, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 24'h20, 0, 8, 0, 24'h20, 24'h20, 0, 1));
      vecs.push_back(mk(0, 24'h20, 0, 8, 0, 24'h20, 0, 0, 0));
      // Reset mid-count: everything cleared, no pulse afterwards
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 24'h20, 8, 0, 24'h20, 0, 0, 0));
      vecs.push_back(mk(1, 0, 24'h20, 8, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 24'h20, 8, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst; io = vecs[i].io; fen = vecs[i].fen;
         thr = vecs[i].thr; psc = vecs[i].psc;
         cyc();
         chk($sformatf("vec%0d pin_o", i), pin_o, vecs[i].pin);
         chk($sformatf("vec%0d rise_o", i), rise_o, vecs[i].rise);
         chk($sformatf("vec%0d fall_o", i), fall_o, vecs[i].fall);
         chk($sformatf("vec%0d any_edge_o", i), any_edge_o, vecs[i].any);
      end

      // Prescaled debounce on pin 10: two ticks of period 10 needed
      rst = 1'b0; fen = 24'h400; thr = 8'd2; psc = 16'd9; io = 24'h400;
      n = 0; seen = 1'b0;
      while (n < 40 && !seen) begin
         cyc();
         n++;
         chk("t4 no fall while waiting", fall_o[10], 0);
         if (pin_o[10]) seen = 1'b1;
      end
      chk("t4 latency within tick window", (n >= 13 && n <= 22 && seen), 1);
      chk("t4 rise pulse on update", rise_o[10], 1);
      // 15-cycle glitch starting right after the tick that updated the pin sees one tick only
      io = 24'h000;
      for (int i = 0; i < 15; i++) begin
         cyc();
         chk("t4 glitch ignored", {pin_o[10], rise_o[10], fall_o[10]}, 3'b100);
      end
      io = 24'h400;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("t4 steady after glitch", {pin_o[10], rise_o[10], fall_o[10]}, 3'b100);
      end

      // Random pads against the reference model, half the pins filtered
      rst = 1'b1; fen = 24'h00FF00; thr = 8'd3; psc = 16'd2; io = '0;
      model_step();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         io = io ^ ($urandom() & $urandom() & $urandom());
         model_step();
         cyc();
         chk($sformatf("rnd%0d pin_o", i), pin_o, m_pin);
         chk($sformatf("rnd%0d rise_o", i), rise_o, m_rise);
         chk($sformatf("rnd%0d fall_o", i), fall_o, m_fall);
         chk($sformatf("rnd%0d any_edge_o", i), any_edge_o, |(m_rise | m_fall));
         chk($sformatf("rnd%0d rise&fall", i), rise_o & fall_o, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
